// File: rtl/placar_pkg.sv
// rtl/placar_pkg.sv - shared state codes, result codes and score limits for placar_ctrl
package placar_pkg;

  localparam logic [3:0] ST_IDLE_CODE      = 4'b0000;
  localparam logic [3:0] ST_ARM_CODE       = 4'b0001;
  localparam logic [3:0] ST_GO_CODE        = 4'b0010;
  localparam logic [3:0] ST_POINT_CODE     = 4'b0011;
  localparam logic [3:0] ST_MATCH_END_CODE = 4'b0100;

  typedef enum logic [3:0] {
    ST_IDLE      = ST_IDLE_CODE,
    ST_ARM       = ST_ARM_CODE,
    ST_GO        = ST_GO_CODE,
    ST_POINT     = ST_POINT_CODE,
    ST_MATCH_END = ST_MATCH_END_CODE
  } state_t;

  localparam logic [1:0] PREMIO_NONE = 2'b00;
  localparam logic [1:0] PREMIO_P1   = 2'b01;
  localparam logic [1:0] PREMIO_P2   = 2'b10;

  localparam int unsigned WIN_SCORE_MIN = 1;
  localparam int unsigned WIN_SCORE_MAX = 9;

  // Keeps the threshold a single displayable digit even if misconfigured.
  function automatic logic [3:0] win_limit(input int unsigned w);
    int unsigned c;
    c = w;
    if (c < WIN_SCORE_MIN) c = WIN_SCORE_MIN;
    if (c > WIN_SCORE_MAX) c = WIN_SCORE_MAX;
    return c[3:0];
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter; expired flags the last cycle of a loaded interval
module cycle_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        en,
  input  logic [31:0] load_value,
  output logic        expired
);

  logic [31:0] count;

  // Loading N yields expired on the Nth following edge, so a state lasts N cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 32'd0;
    end else if (load) begin
      count <= load_value;
    end else if (en && count > 32'd1) begin
      count <= count - 32'd1;
    end
  end

  assign expired = (count <= 32'd1);

endmodule

// File: rtl/placar_ctrl.sv
// rtl/placar_ctrl.sv - two-player reaction-round match controller; FALSE_START_EN enables false-start penalties
module placar_ctrl
  import placar_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
  parameter int unsigned HOLD_CYCLES    = 100_000_000,
  parameter int unsigned WIN_SCORE      = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       btn_p1,
  input  logic       btn_p2,
  output logic       go,
  output logic [1:0] premio_f,
  output logic [3:0] p1_f,
  output logic [3:0] p2_f,
  output logic [3:0] state_f
);

  localparam logic [3:0]  WIN     = win_limit(WIN_SCORE);
  localparam logic [31:0] WAIT_V  = WAIT_CYCLES;
  localparam logic [31:0] TOUT_V  = TIMEOUT_CYCLES;
  localparam logic [31:0] HOLD_V  = HOLD_CYCLES;

  state_t      state, state_nxt;
  logic        token;  // 0: P1 holds tie priority, 1: P2
  logic        expired, timer_load, timer_en;
  logic [31:0] timer_value;
  logic        p1_inc, p2_inc, tok_flip, clear;

  cycle_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .en         (timer_en),
    .load_value (timer_value),
    .expired    (expired)
  );

  assign timer_en = (state == ST_ARM) || (state == ST_GO) || (state == ST_POINT);
  assign state_f  = state;

  // Presses take precedence over timer expiry in every state that honours them.
  always_comb begin
    state_nxt   = state;
    timer_load  = 1'b0;
    timer_value = WAIT_V;
    p1_inc      = 1'b0;
    p2_inc      = 1'b0;
    tok_flip    = 1'b0;
    clear       = 1'b0;
    case (state)
      ST_IDLE: begin
        clear = 1'b1;
        if (start) begin
          state_nxt  = ST_ARM;
          timer_load = 1'b1;
        end
      end
      ST_ARM: begin
`ifdef FALSE_START_EN
        if (btn_p1 && btn_p2) begin
          timer_load = 1'b1;
        end else if (btn_p1 || btn_p2) begin
          p1_inc      = btn_p2;
          p2_inc      = btn_p1;
          state_nxt   = ST_POINT;
          timer_load  = 1'b1;
          timer_value = HOLD_V;
        end else
`endif
        if (expired) begin
          state_nxt   = ST_GO;
          timer_load  = 1'b1;
          timer_value = TOUT_V;
        end
      end
      ST_GO: begin
        if (btn_p1 || btn_p2) begin
          if (btn_p1 && btn_p2) begin
            tok_flip = 1'b1;
            p1_inc   = !token;
            p2_inc   = token;
          end else begin
            p1_inc = btn_p1;
            p2_inc = btn_p2;
          end
          state_nxt   = ST_POINT;
          timer_load  = 1'b1;
          timer_value = HOLD_V;
        end else if (expired) begin
          state_nxt  = ST_ARM;
          timer_load = 1'b1;
        end
      end
      ST_POINT: begin
        if (expired) begin
          if (p1_f == WIN || p2_f == WIN) begin
            state_nxt = ST_MATCH_END;
          end else begin
            state_nxt  = ST_ARM;
            timer_load = 1'b1;
          end
        end
      end
      ST_MATCH_END: begin
        if (start) begin
          clear      = 1'b1;
          state_nxt  = ST_ARM;
          timer_load = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      go       <= 1'b0;
      premio_f <= PREMIO_NONE;
      p1_f     <= 4'd0;
      p2_f     <= 4'd0;
      token    <= 1'b0;
    end else begin
      state <= state_nxt;
      go    <= (state_nxt == ST_GO);
      if (clear) begin
        premio_f <= PREMIO_NONE;
        p1_f     <= 4'd0;
        p2_f     <= 4'd0;
        token    <= 1'b0;
      end else begin
        if (p1_inc && p1_f < WIN) p1_f <= p1_f + 4'd1;
        if (p2_inc && p2_f < WIN) p2_f <= p2_f + 4'd1;
        if (tok_flip) token <= !token;
        if (state == ST_POINT && state_nxt == ST_MATCH_END)
          premio_f <= (p1_f == WIN) ? PREMIO_P1 : PREMIO_P2;
      end
    end
  end

endmodule

// File: tb/tb_placar_ctrl.sv
// tb/tb_placar_ctrl.sv - directed self-checking bench for placar_ctrl with short timing parameters
module tb_placar_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       btn_p1 = 1'b0;
  logic       btn_p2 = 1'b0;
  logic       go;
  logic [1:0] premio_f;
  logic [3:0] p1_f, p2_f, state_f;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] S_IDLE = 4'b0000, S_ARM = 4'b0001, S_GO = 4'b0010,
                         S_POINT = 4'b0011, S_END = 4'b0100;

  placar_ctrl #(
    .WAIT_CYCLES(4), .TIMEOUT_CYCLES(6), .HOLD_CYCLES(3), .WIN_SCORE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .btn_p1(btn_p1), .btn_p2(btn_p2),
    .go(go), .premio_f(premio_f), .p1_f(p1_f), .p2_f(p2_f), .state_f(state_f)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] st, input logic g,
                            input logic [3:0] s1, input logic [3:0] s2, input logic [1:0] pr);
    check({tag, ".state"}, 32'(state_f), 32'(st));
    check({tag, ".go"}, 32'(go), 32'(g));
    check({tag, ".p1"}, 32'(p1_f), 32'(s1));
    check({tag, ".p2"}, 32'(p2_f), 32'(s2));
    check({tag, ".premio"}, 32'(premio_f), 32'(pr));
  endtask

  // Called on the first ARM cycle; GO must appear after exactly four ARM cycles.
  task automatic arm_to_go(input string tag);
    step(3);
    check({tag, ".arm_hold"}, 32'(state_f), 32'(S_ARM));
    check({tag, ".arm_go"}, 32'(go), 32'd0);
    step(1);
    check({tag, ".go_state"}, 32'(state_f), 32'(S_GO));
    check({tag, ".go"}, 32'(go), 32'd1);
  endtask

  task automatic press(input logic b1, input logic b2);
    btn_p1 = b1;
    btn_p2 = b2;
    step(1);
    btn_p1 = 1'b0;
    btn_p2 = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic hold_then(input string tag, input logic [3:0] after);
    step(2);
    check({tag, ".point_hold"}, 32'(state_f), 32'(S_POINT));
    step(1);
    check({tag, ".after_point"}, 32'(state_f), 32'(after));
  endtask

  initial begin
    step(3);
    expect_out("reset", S_IDLE, 0, 0, 0, 2'b00);
    rst_n = 1'b1;
    step(1);
    expect_out("idle", S_IDLE, 0, 0, 0, 2'b00);

    pulse_start();
    expect_out("start", S_ARM, 0, 0, 0, 2'b00);
    arm_to_go("r1");
    step(1);
    press(1, 0);
    expect_out("p1_point", S_POINT, 0, 1, 0, 2'b00);
    hold_then("r1", S_ARM);

    arm_to_go("tmo");
    step(5);
    check("tmo.still_go", 32'(state_f), 32'(S_GO));
    step(1);
    expect_out("tmo.void", S_ARM, 0, 1, 0, 2'b00);

    arm_to_go("rst");
    step(1);
    rst_n = 1'b0;
    step(1);
    expect_out("rst_mid_go", S_IDLE, 0, 0, 0, 2'b00);
    rst_n = 1'b1;

    pulse_start();
    arm_to_go("tie1");
    press(1, 1);
    expect_out("tie1", S_POINT, 0, 1, 0, 2'b00);
    hold_then("tie1", S_ARM);
    arm_to_go("tie2");
    press(1, 1);
    expect_out("tie2", S_POINT, 0, 1, 1, 2'b00);
    hold_then("tie2", S_ARM);
    arm_to_go("tie3");
    press(1, 1);
    expect_out("tie3", S_POINT, 0, 2, 1, 2'b00);
    hold_then("tie3", S_END);
    check("p1_win.premio", 32'(premio_f), 32'd1);

    press(0, 1);
    expect_out("end_ignore_btn", S_END, 0, 2, 1, 2'b01);
    pulse_start();
    expect_out("restart", S_ARM, 0, 0, 0, 2'b00);

    arm_to_go("p2a");
    pulse_start();
    check("start_ignored_go", 32'(state_f), 32'(S_GO));
    press(0, 1);
    expect_out("p2a", S_POINT, 0, 0, 1, 2'b00);
    hold_then("p2a", S_ARM);
    arm_to_go("p2b");
    press(0, 1);
    expect_out("p2b", S_POINT, 0, 0, 2, 2'b00);
    hold_then("p2b", S_END);
    expect_out("p2_win", S_END, 0, 0, 2, 2'b10);
    pulse_start();
    expect_out("restart2", S_ARM, 0, 0, 0, 2'b00);

    press(1, 0);
`ifdef FALSE_START_EN
    expect_out("false_start", S_POINT, 0, 0, 1, 2'b00);
`else
    expect_out("arm_press", S_ARM, 0, 0, 0, 2'b00);
    step(2);
    check("arm_press.arm", 32'(state_f), 32'(S_ARM));
    step(1);
    check("arm_press.go", 32'(state_f), 32'(S_GO));
    check("arm_press.go_sig", 32'(go), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/placar_ctrl.md
# placar_ctrl

Two-player match controller that sequences the scoreboard display. It runs reaction rounds: arm, then "go", then the first button press wins the point. It arbitrates simultaneous presses, tracks both scores up to a win threshold and declares the match winner. Its registered outputs drive the display block's prize, score and state inputs directly.

## Interface
- `WAIT_CYCLES`, default 50_000_000: cycles spent in ARM before `go` asserts.
- `TIMEOUT_CYCLES`, default 250_000_000: cycles allowed in GO before the round is voided.
- `HOLD_CYCLES`, default 100_000_000: cycles the POINT state is held for display.
- `WIN_SCORE`, default 9: score that ends the match; legal range 1..9 (single digit).
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse, synchronized; starts a match or restarts after one ends.
- `btn_p1` in 1: player 1 press; one-cycle pulse, synchronized and debounced upstream.
- `btn_p2` in 1: player 2 press; same conditioning as `btn_p1`.
- `go` out 1: high in GO only; the players' cue.
- `premio_f` out 2: match result; 00 none, 01 player 1 won, 10 player 2 won.
- `p1_f` out 4: player 1 score, unsigned.
- `p2_f` out 4: player 2 score, unsigned.
- `state_f` out 4: current state code.

## Operation
- State codes (4 bits):
  - IDLE = 0000
  - ARM = 0001
  - GO = 0010
  - POINT = 0011
  - MATCH_END = 0100
  - Other codes unused; reaching one forces IDLE.
- IDLE:
  - Scores and `premio_f` held at 0.
  - `start` → ARM, timer loaded with WAIT_CYCLES.
- ARM:
  - Timer counts down; on expiry → GO, timer loaded with TIMEOUT_CYCLES.
  - Button presses here are governed by the configuration macro.
- GO:
  - Exactly one of `btn_p1`/`btn_p2` high → that player scores, → POINT.
  - Both high in the same cycle → the holder of the priority token scores, then the token flips.
  - Token is P1 at reset; it changes only on a tie.
  - Timer expiry with no press → ARM (round voided, no score change).
- POINT:
  - Hold for HOLD_CYCLES.
  - Then, if either score equals WIN_SCORE → MATCH_END; otherwise → ARM.
- MATCH_END:
  - `premio_f` = winner code; scores frozen.
  - `start` → scores and `premio_f` cleared, token reset to P1, → ARM.
- Scores saturate at WIN_SCORE and never wrap.
- Button presses in IDLE, POINT and MATCH_END are ignored.
- `start` is ignored outside IDLE and MATCH_END.

## Timing
- All outputs registered. Reset value of every output is 0, and state is IDLE.
- Reset has priority over every event, including mid-round; the timer and token also clear.
- `start` sampled at edge N → `state_f` = ARM from cycle N+1.
- Entering ARM at cycle N → `go` = 1 and `state_f` = GO from cycle N+WAIT_CYCLES.
- Press sampled in GO at edge N → incremented score and `state_f` = POINT visible at N+1; `go` = 0 at N+1.
- POINT is entered at N+1 and left at N+1+HOLD_CYCLES.
- Timeout: GO lasts exactly TIMEOUT_CYCLES cycles.
- If a press and timer expiry land on the same edge, the press wins.
- Final point → `premio_f` valid in the same cycle `state_f` = MATCH_END.

## Configuration
- `FALSE_START_EN` defined:
  - A press in ARM awards the point to the opponent → POINT.
  - If both players press in the same ARM cycle, no point is awarded and ARM restarts with the timer reloaded.
- `FALSE_START_EN` undefined: presses in ARM are ignored and ARM always runs to expiry.

## Structure
- Shared package `placar_pkg` holds:
  - The state-code localparams.
  - The `premio_f` codes (NONE/P1/P2).
  - The `WIN_SCORE` range limit.
- One sub-module, `cycle_timer`: a loadable down-counter with a 32-bit load value and `load`, `en` and `expired` signals. It is shared by ARM, GO and POINT, and reloaded on every state entry.

## Test plan
Benches set WAIT=4, TIMEOUT=6, HOLD=3, WIN_SCORE=2.
- Reset, then `start` at edge 0 → ARM at 1; `go` = 1 from cycle 5.
- P1 press 2 cycles into GO → `p1_f` = 1 and `state_f` = 0011 next cycle; ARM again 3 cycles later.
- Simultaneous presses in two successive GO states → first point to P1, second to P2; token back to P1 afterwards.
- No press in GO → after 6 cycles `state_f` = 0001 and scores unchanged.
- P2 wins two rounds → `state_f` = 0100, `premio_f` = 10, `p2_f` = 2; `start` → scores 0, ARM.
- With `FALSE_START_EN`, P1 press in ARM → `p2_f` increments. Without it → no change, and GO is still reached on schedule.
- `rst_n` low mid-GO → next cycle all outputs 0 and state IDLE.
